// File: rtl/booth4_mac_nbit.sv
// -----------------------------------------------------------------------------
// booth4_mac_nbit
//   Radix-4 Booth multiply-accumulate unit. Computes
//     m_res = op1 * op2 (+ s_acc when s_acc_en)   modulo 2^(2*MUL_SIZE)
//   with independent signedness per operand. DIGITS_PER_CYCLE radix-4 digits
//   are retired every CALC cycle. Valid/ready on both sides. A new operation
//   can be accepted on the same edge that the previous result is consumed.
//
// Parameters
//   MUL_SIZE          operand width N (even, >= 4)
//   DIGITS_PER_CYCLE  radix-4 digits per CALC cycle D (1, 2 or 4)
//   RES_SIZE          result/addend width, fixed at 2*MUL_SIZE
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   s_valid/s_ready   operand handshake
//   s_op1, s_op2      multiplicand, multiplier
//   s_op1_signed      1 = s_op1 is two's complement
//   s_op2_signed      1 = s_op2 is two's complement
//   s_acc_en, s_acc   optional addend
//   flush             synchronous abort; beats accept and completion
//   m_valid/m_ready   result handshake
//   m_res             registered result, 0 whenever m_valid is low
//   busy              high in CALC or DONE
// -----------------------------------------------------------------------------
module booth4_mac_nbit #(
  parameter  int MUL_SIZE         = 32,
  parameter  int DIGITS_PER_CYCLE = 1,
  localparam int RES_SIZE         = 2 * MUL_SIZE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [MUL_SIZE-1:0] s_op1,
  input  logic [MUL_SIZE-1:0] s_op2,
  input  logic                s_op1_signed,
  input  logic                s_op2_signed,
  input  logic                s_acc_en,
  input  logic [RES_SIZE-1:0] s_acc,
  input  logic                flush,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [RES_SIZE-1:0] m_res,
  output logic                busy
);

  // One extra digit beyond N/2 so unsigned operands decode correctly.
  localparam int NUM_DIGITS = MUL_SIZE / 2 + 1;
  localparam int NUM_CYCLES = (NUM_DIGITS + DIGITS_PER_CYCLE - 1) / DIGITS_PER_CYCLE;
  localparam int CNT_W      = (NUM_CYCLES > 1) ? $clog2(NUM_CYCLES) : 1;
  localparam int SHIFT      = 2 * DIGITS_PER_CYCLE;
  // Multiplier register {ext, ext, op2, 0} padded with SHIFT more ext bits so
  // every window of the last cycle stays inside the vector.
  localparam int MW         = MUL_SIZE + 3 + SHIFT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [RES_SIZE-1:0] r_sum;
  logic [RES_SIZE-1:0] r_mcand;   // multiplicand, pre-weighted for digit 0 of this cycle
  logic [MW-1:0]       r_mplier;  // multiplier, current low window at bits [2:0]
  logic [RES_SIZE-1:0] r_res;

  logic                w_accept;
  logic                w_calc_last;
  logic                w_op1_ext;
  logic                w_op2_ext;
  logic [RES_SIZE-1:0] w_acc;

  assign s_ready     = (r_state == IDLE) || ((r_state == DONE) && m_ready);
  assign w_accept    = s_valid && s_ready && !flush;
  assign w_calc_last = (r_state == CALC) && (r_cnt == '0);
  assign w_op1_ext   = s_op1_signed & s_op1[MUL_SIZE-1];
  assign w_op2_ext   = s_op2_signed & s_op2[MUL_SIZE-1];

  assign m_valid = (r_state == DONE);
  assign m_res   = r_res;
  assign busy    = (r_state != IDLE);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: the default at the top of every combinational block guarantees each
  // path assigns the output, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_state_nxt = CALC;
        CALC:    if (w_calc_last) w_state_nxt = DONE;
        DONE:    if (m_ready) w_state_nxt = w_accept ? CALC : IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Booth digit adder: DIGITS_PER_CYCLE weighted partial products per cycle.
  // Negative digits add the inverted multiple plus a carry-in of one.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [2:0]          win;
    logic [RES_SIZE-1:0] x_w;
    logic [RES_SIZE-1:0] pp;
    logic                neg;
    w_acc = r_sum;
    win   = '0;
    x_w   = '0;
    pp    = '0;
    neg   = 1'b0;
    for (int j = 0; j < DIGITS_PER_CYCLE; j++) begin
      win = r_mplier[2*j +: 3];
      x_w = r_mcand << (2 * j);
      pp  = '0;
      neg = 1'b0;
      case (win)
        3'b001, 3'b010: pp = x_w;
        3'b011:         pp = x_w << 1;
        3'b100: begin   pp = x_w << 1; neg = 1'b1; end
        3'b101, 3'b110: begin pp = x_w; neg = 1'b1; end
        default:        pp = '0;
      endcase
      w_acc = w_acc + (neg ? ~pp : pp) + {{(RES_SIZE-1){1'b0}}, neg};
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_sum    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_res    <= '0;
    end else begin
      if (w_accept) begin
        r_cnt    <= CNT_W'(NUM_CYCLES - 1);
        r_sum    <= s_acc_en ? s_acc : '0;
        r_mcand  <= {{MUL_SIZE{w_op1_ext}}, s_op1};
        r_mplier <= {{(SHIFT + 2){w_op2_ext}}, s_op2, 1'b0};
      end else if (r_state == CALC) begin
        r_cnt    <= r_cnt - CNT_W'(1);
        r_sum    <= w_acc;
        r_mcand  <= r_mcand << SHIFT;
        // Arithmetic shift: digits past the last one decode to 0.
        r_mplier <= {{SHIFT{r_mplier[MW-1]}}, r_mplier[MW-1:SHIFT]};
      end

      // Result is held while m_valid is up and cleared whenever it drops.
      if (flush)                             r_res <= '0;
      else if (w_calc_last)                  r_res <= w_acc;
      else if ((r_state == DONE) && m_ready) r_res <= '0;
    end
  end

endmodule

// File: tb/tb_booth4_mac_nbit.sv
// -----------------------------------------------------------------------------
// tb_booth4_mac_nbit
//   Three N=32 instances (D = 1, 2, 4). A negedge monitor compares every
//   instance's outputs against a protocol/arithmetic model each cycle; the
//   directed sequences also compare against hand-computed literals.
// -----------------------------------------------------------------------------
module tb_booth4_mac_nbit;

  localparam int NI = 3;

  logic        clk;
  logic        rst_n;
  logic        s_valid [NI];
  logic        s_ready [NI];
  logic        m_valid [NI];
  logic        m_ready [NI];
  logic        flush   [NI];
  logic        busy    [NI];
  logic [63:0] m_res   [NI];
  logic [31:0] s_op1;
  logic [31:0] s_op2;
  logic        s_op1_signed;
  logic        s_op2_signed;
  logic        s_acc_en;
  logic [63:0] s_acc;

  int n_chk = 0;
  int n_err = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    booth4_mac_nbit #(
      .MUL_SIZE        (32),
      .DIGITS_PER_CYCLE((g == 0) ? 1 : ((g == 1) ? 2 : 4))
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_valid     (s_valid[g]),
      .s_ready     (s_ready[g]),
      .s_op1       (s_op1),
      .s_op2       (s_op2),
      .s_op1_signed(s_op1_signed),
      .s_op2_signed(s_op2_signed),
      .s_acc_en    (s_acc_en),
      .s_acc       (s_acc),
      .flush       (flush[g]),
      .m_valid     (m_valid[g]),
      .m_ready     (m_ready[g]),
      .m_res       (m_res[g]),
      .busy        (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles from accept edge to m_valid: ceil(17 / D).
  function automatic int lat(int k);
    return (k == 0) ? 17 : ((k == 1) ? 9 : 5);
  endfunction

  function automatic logic [63:0] ref_mac(logic [31:0] a, logic [31:0] b,
                                          logic sa, logic sb, logic ae,
                                          logic [63:0] acc);
    logic [63:0] xa;
    logic [63:0] xb;
    xa = sa ? {{32{a[31]}}, a} : {32'b0, a};
    xb = sb ? {{32{b[31]}}, b} : {32'b0, b};
    return xa * xb + (ae ? acc : 64'd0);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model + compare process
  // ---------------------------------------------------------------------------
  bit          mdl_busy [NI];
  bit          mdl_valid[NI];
  int          mdl_cnt  [NI];
  logic [63:0] mdl_res  [NI];

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        mdl_busy[k]  = 1'b0;
        mdl_valid[k] = 1'b0;
        check($sformatf("rst m_valid[%0d]", k), 64'(m_valid[k]), 64'd0);
        check($sformatf("rst s_ready[%0d]", k), 64'(s_ready[k]), 64'd1);
        check($sformatf("rst busy[%0d]", k),    64'(busy[k]),    64'd0);
        check($sformatf("rst m_res[%0d]", k),   m_res[k],        64'd0);
      end else begin
        bit exp_rdy;
        exp_rdy = !mdl_busy[k] || (mdl_valid[k] && m_ready[k]);
        check($sformatf("mon m_valid[%0d]", k), 64'(m_valid[k]), 64'(mdl_valid[k]));
        check($sformatf("mon m_res[%0d]", k), m_res[k], mdl_valid[k] ? mdl_res[k] : 64'd0);
        check($sformatf("mon s_ready[%0d]", k), 64'(s_ready[k]), 64'(exp_rdy));
        check($sformatf("mon busy[%0d]", k),    64'(busy[k]),    64'(mdl_busy[k]));
        // Advance the model to the state after the coming edge.
        if (flush[k]) begin
          mdl_busy[k]  = 1'b0;
          mdl_valid[k] = 1'b0;
        end else begin
          if (mdl_valid[k] && m_ready[k]) begin
            mdl_valid[k] = 1'b0;
            mdl_busy[k]  = 1'b0;
          end else if (mdl_busy[k] && !mdl_valid[k]) begin
            mdl_cnt[k]--;
            if (mdl_cnt[k] == 0) mdl_valid[k] = 1'b1;
          end
          if (s_valid[k] && exp_rdy) begin
            mdl_busy[k]  = 1'b1;
            mdl_valid[k] = 1'b0;
            mdl_cnt[k]   = lat(k);
            mdl_res[k]   = ref_mac(s_op1, s_op2, s_op1_signed, s_op2_signed, s_acc_en, s_acc);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. All called at posedge+1.
  // ---------------------------------------------------------------------------
  task automatic issue(int k, logic [31:0] a, logic [31:0] b, logic sa, logic sb,
                       logic ae, logic [63:0] acc);
    s_op1 = a; s_op2 = b; s_op1_signed = sa; s_op2_signed = sb;
    s_acc_en = ae; s_acc = acc;
    s_valid[k] = 1'b1;
    @(posedge clk); #1;
    s_valid[k] = 1'b0;
  endtask

  // Starts just after the accept edge; checks latency and value.
  task automatic wait_result(int k, logic [63:0] exp, string name);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (m_valid[k]) seen = 1'b1;
    end
    check({name, " latency"}, 64'(n), 64'(lat(k)));
    check({name, " result"}, m_res[k], exp);
  endtask

  task automatic basic_set(int k);
    issue(k, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1, 1'b0, 64'd0);
    wait_result(k, 64'hFFFF_FFFF_FFFF_FFF1, $sformatf("d%0d neg3x5", k));
    @(posedge clk); #1;
    issue(k, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 64'd0);
    wait_result(k, 64'hFFFF_FFFE_0000_0001, $sformatf("d%0d uu max", k));
    // Back-to-back: issue on the consume edge.
    issue(k, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 64'd0);
    wait_result(k, 64'h4000_0000_0000_0000, $sformatf("d%0d ss min", k));
    @(posedge clk); #1;
    issue(k, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 64'd0);
    wait_result(k, 64'hFFFF_FFFF_0000_0001, $sformatf("d%0d su", k));
    @(posedge clk); #1;
    issue(k, 32'd7, 32'd6, 1'b0, 1'b0, 1'b1, 64'h100);
    wait_result(k, 64'h12A, $sformatf("d%0d mac", k));
    @(posedge clk); #1;
    issue(k, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_result(k, 64'h0, $sformatf("d%0d wrap", k));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      s_valid[k] = 1'b0;
      m_ready[k] = 1'b1;
      flush[k]   = 1'b0;
    end
    s_op1 = '0; s_op2 = '0; s_op1_signed = 1'b0; s_op2_signed = 1'b0;
    s_acc_en = 1'b0; s_acc = '0;
    #22 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < NI; k++) basic_set(k);

    // Backpressure then back-to-back accept on the consume edge.
    m_ready[0] = 1'b0;
    issue(0, 32'd10, 32'd10, 1'b0, 1'b0, 1'b0, 64'd0);
    wait_result(0, 64'd100, "bp first");
    repeat (10) begin
      @(posedge clk); #1;
      check("bp m_valid", 64'(m_valid[0]), 64'd1);
      check("bp m_res",   m_res[0],        64'd100);
      check("bp s_ready", 64'(s_ready[0]), 64'd0);
    end
    m_ready[0] = 1'b1;
    issue(0, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 64'd0);
    check("b2b m_valid drop", 64'(m_valid[0]), 64'd0);
    check("b2b busy",         64'(busy[0]),    64'd1);
    wait_result(0, 64'd6, "b2b 2x3");
    @(posedge clk); #1;

    // Flush during the 5th CALC cycle.
    issue(0, 32'd12345, 32'd678, 1'b0, 1'b0, 1'b0, 64'd0);
    repeat (4) @(posedge clk);
    #1 flush[0] = 1'b1;
    @(posedge clk); #1;
    flush[0] = 1'b0;
    check("flush calc s_ready", 64'(s_ready[0]), 64'd1);
    check("flush calc busy",    64'(busy[0]),    64'd0);
    repeat (20) begin
      @(posedge clk); #1;
      check("flush calc no valid", 64'(m_valid[0]), 64'd0);
    end
    issue(0, 32'd9, 32'd9, 1'b0, 1'b0, 1'b0, 64'd0);
    wait_result(0, 64'd81, "after flush 9x9");
    @(posedge clk); #1;

    // Flush in DONE with m_ready=1 and s_valid=1: nothing transfers or starts.
    m_ready[0] = 1'b0;
    issue(0, 32'd4, 32'd4, 1'b0, 1'b0, 1'b0, 64'd0);
    wait_result(0, 64'd16, "pre done-flush");
    m_ready[0] = 1'b1;
    flush[0]   = 1'b1;
    s_valid[0] = 1'b1;
    @(posedge clk); #1;
    flush[0]   = 1'b0;
    s_valid[0] = 1'b0;
    check("flush done m_valid", 64'(m_valid[0]), 64'd0);
    check("flush done m_res",   m_res[0],        64'd0);
    check("flush done busy",    64'(busy[0]),    64'd0);
    @(posedge clk); #1;

    // Asynchronous reset mid-CALC.
    issue(0, 32'd1000, 32'd1000, 1'b0, 1'b0, 1'b0, 64'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst busy",    64'(busy[0]),    64'd0);
    check("async rst s_ready", 64'(s_ready[0]), 64'd1);
    check("async rst m_valid", 64'(m_valid[0]), 64'd0);
    check("async rst m_res",   m_res[0],        64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(0, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0, 64'd0);
    wait_result(0, 64'd25, "after reset 5x5");
    @(posedge clk); #1;

    // Random regression on all three instances.
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < NI; k++) begin
        logic [31:0] a;
        logic [31:0] b;
        logic        sa;
        logic        sb;
        logic        ae;
        logic [63:0] acc;
        a   = $urandom;
        b   = $urandom;
        sa  = 1'($urandom_range(0, 1));
        sb  = 1'($urandom_range(0, 1));
        ae  = 1'($urandom_range(0, 1));
        acc = {$urandom, $urandom};
        issue(k, a, b, sa, sb, ae, acc);
        wait_result(k, ref_mac(a, b, sa, sb, ae, acc), $sformatf("rand d%0d #%0d", k, i));
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
